// File: rtl/oam_dma.sv
// Sprite-memory DMA: a $4014 write halts the CPU and copies page {page,00..FF} to $2004.
// Optional build macro OAM_DMA_ALIGN_EN adds the odd-cycle ALIGN stall before the first read.
module oam_dma (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_en,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_read,
  output logic        bus_write,
  input  logic [7:0]  bus_rdata,
  output logic        dma_busy,
  output logic [2:0]  dbg_state,
  output logic [7:0]  dbg_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
`ifdef OAM_DMA_ALIGN_EN
    ST_ALIGN = 3'd2,
`endif
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  state_t     state_q;
  logic [7:0] page_q;
  logic [7:0] cnt_q;
  logic [7:0] data_q;
  logic       parity_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      page_q   <= 8'h00;
      cnt_q    <= 8'h00;
      data_q   <= 8'h00;
      parity_q <= 1'b0;
    end else if (tick) begin
      // parity tracks CPU cycle phase regardless of DMA activity
      parity_q <= ~parity_q;
      case (state_q)
        ST_IDLE: begin
          if (cpu_write && (cpu_addr == 16'h4014)) begin
            page_q  <= cpu_wdata;
            cnt_q   <= 8'h00;
            state_q <= ST_HALT;
          end
        end
        ST_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
          state_q <= parity_q ? ST_READ : ST_ALIGN;
`else
          state_q <= ST_READ;
`endif
        end
`ifdef OAM_DMA_ALIGN_EN
        ST_ALIGN: state_q <= ST_READ;
`endif
        ST_READ: begin
          data_q  <= bus_rdata;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          cnt_q   <= cnt_q + 8'd1;
          state_q <= (cnt_q == 8'hFF) ? ST_IDLE : ST_READ;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Bus mux: CPU owns the bus in IDLE, DMA drives it in READ/WRITE, strobes quiet otherwise.
  always_comb begin
    bus_addr  = cpu_addr;
    bus_wdata = cpu_wdata;
    bus_read  = 1'b0;
    bus_write = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus_read  = cpu_read;
        bus_write = cpu_write;
      end
      ST_READ: begin
        bus_addr = {page_q, cnt_q};
        bus_read = 1'b1;
      end
      ST_WRITE: begin
        bus_addr  = 16'h2004;
        bus_wdata = data_q;
        bus_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign cpu_rdata = bus_rdata;
  assign cpu_en    = tick & (state_q == ST_IDLE);
  assign dma_busy  = (state_q != ST_IDLE);
  assign dbg_state = state_q;
  assign dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: random memory image, scoreboard of expected bus operations,
// per-scenario tasks with inline checks. Honours OAM_DMA_ALIGN_EN for the ALIGN tick count.
module tb_oam_dma;

  logic        clk;
  logic        reset;
  logic        tick;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_read;
  logic        cpu_write;
  logic [7:0]  cpu_rdata;
  logic        cpu_en;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_read;
  logic        bus_write;
  logic [7:0]  bus_rdata;
  logic        dma_busy;
  logic [2:0]  dbg_state;
  logic [7:0]  dbg_cnt;

  logic [7:0]  mem [0:65535];
  logic [24:0] exp_q[$];

  int checks;
  int errors;
  int tick_cnt;
  int busy_ticks;
  int quiet_ticks;
  int wr_seen;

  logic [2:0]  snap_state;
  logic [7:0]  snap_cnt;
  bit          snap_valid;
  logic [24:0] mon_obs;
  logic [24:0] mon_exp;

  oam_dma dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_rdata (cpu_rdata),
    .cpu_en    (cpu_en),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_read  (bus_read),
    .bus_write (bus_write),
    .bus_rdata (bus_rdata),
    .dma_busy  (dma_busy),
    .dbg_state (dbg_state),
    .dbg_cnt   (dbg_cnt)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign bus_rdata = mem[bus_addr];

  // Scoreboard monitor: samples 3ns after each negedge, i.e. 2ns before the rising edge.
  always begin
    @(negedge clk);
    #3;
    if (reset) begin
      tick_cnt   = 0;
      snap_valid = 0;
    end else begin
      if (snap_valid) begin
        checks++;
        if (dbg_state !== snap_state || dbg_cnt !== snap_cnt) begin
          errors++;
          $display("FAIL frozen_on_tick0: state=%0d cnt=%0h required state=%0d cnt=%0h",
                   dbg_state, dbg_cnt, snap_state, snap_cnt);
        end
      end
      snap_valid = !tick;
      snap_state = dbg_state;
      snap_cnt   = dbg_cnt;
      checks++;
      if (cpu_en !== (tick && !dma_busy)) begin
        errors++;
        $display("FAIL cpu_en_gate: cpu_en=%b required %b (tick=%b busy=%b)",
                 cpu_en, tick && !dma_busy, tick, dma_busy);
      end
      if (tick) begin
        tick_cnt++;
        if (dma_busy === 1'b1) begin
          busy_ticks++;
          if (bus_read === 1'b1 || bus_write === 1'b1) begin
            mon_obs = {bus_write, bus_addr, (bus_write === 1'b1) ? bus_wdata : 8'h00};
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_op: got wr=%b addr=%h data=%h required no operation",
                       mon_obs[24], mon_obs[23:8], mon_obs[7:0]);
            end else begin
              mon_exp = exp_q.pop_front();
              if (mon_obs !== mon_exp) begin
                errors++;
                $display("FAIL dma_op: got wr=%b addr=%h data=%h required wr=%b addr=%h data=%h",
                         mon_obs[24], mon_obs[23:8], mon_obs[7:0],
                         mon_exp[24], mon_exp[23:8], mon_exp[7:0]);
              end
            end
            if (bus_write === 1'b1) wr_seen++;
          end else begin
            quiet_ticks++;
          end
        end
      end
    end
  end

  // driver tasks
  task automatic cycle(input logic t);
    tick = t;
    @(negedge clk);
  endtask

  function automatic int exp_busy(input logic halt_par);
`ifdef OAM_DMA_ALIGN_EN
    return halt_par ? 513 : 514;
`else
    return 513;
`endif
  endfunction

  // Queue the 256 read/write pairs and issue the trigger so parity at HALT equals halt_par.
  task automatic start_dma(input logic [7:0] page, input logic halt_par);
    cpu_write = 1'b0;
    cpu_read  = 1'b0;
    cpu_addr  = 16'h0000;
    if ((tick_cnt % 2) != (halt_par ? 0 : 1)) cycle(1'b1);
    for (int i = 0; i < 256; i++) begin
      logic [15:0] a;
      a = {page, 8'(i)};
      exp_q.push_back({1'b0, a, 8'h00});
      exp_q.push_back({1'b1, 16'h2004, mem[a]});
    end
    busy_ticks  = 0;
    quiet_ticks = 0;
    wr_seen     = 0;
    cpu_addr  = 16'h4014;
    cpu_wdata = page;
    cpu_write = 1'b1;
    cycle(1'b1);
    cpu_write = 1'b0;
    cpu_addr  = 16'(($urandom_range(0, 16'h3FFF)));
    cpu_wdata = 8'($urandom);
  endtask

  task automatic end_checks(input string name, input int n, input int budget, input logic halt_par);
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles", name, n);
    end
    checks++;
    if (busy_ticks != exp_busy(halt_par)) begin
      errors++;
      $display("FAIL %s_busy_ticks: got %0d required %0d", name, busy_ticks, exp_busy(halt_par));
    end
    checks++;
    if (quiet_ticks != exp_busy(halt_par) - 512) begin
      errors++;
      $display("FAIL %s_quiet_ticks: got %0d required %0d", name, quiet_ticks, exp_busy(halt_par) - 512);
    end
    checks++;
    if (exp_q.size() != 0 || wr_seen != 256) begin
      errors++;
      $display("FAIL %s_ops: left=%0d writes=%0d required left=0 writes=256", name, exp_q.size(), wr_seen);
    end
    checks++;
    if (dbg_state !== 3'd0 || dbg_cnt !== 8'h00) begin
      errors++;
      $display("FAIL %s_final: state=%0d cnt=%0h required state=0 cnt=00", name, dbg_state, dbg_cnt);
    end
    exp_q.delete();
  endtask

  // scenarios
  task automatic test_reset;
    tick = 1'b1;
    #1;
    checks++;
    if (dma_busy !== 1'b0 || dbg_state !== 3'd0 || dbg_cnt !== 8'h00 || cpu_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: busy=%b state=%0d cnt=%0h cpu_en=%b required 0 0 00 1",
               dma_busy, dbg_state, dbg_cnt, cpu_en);
    end
    tick = 1'b0;
    #1;
    checks++;
    if (cpu_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_cpu_en: cpu_en=%b required 0", cpu_en);
    end
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b0);
  endtask

  task automatic test_passthrough;
    mem[16'h8000] = 8'h5A;
    cpu_addr  = 16'h8000;
    cpu_read  = 1'b1;
    cpu_write = 1'b0;
    tick      = 1'b1;
    #1;
    checks++;
    if (bus_addr !== 16'h8000 || bus_read !== 1'b1 || bus_write !== 1'b0 ||
        cpu_rdata !== 8'h5A || cpu_en !== 1'b1) begin
      errors++;
      $display("FAIL passthrough_8000: addr=%h rd=%b wr=%b rdata=%h en=%b required 8000 1 0 5a 1",
               bus_addr, bus_read, bus_write, cpu_rdata, cpu_en);
    end
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      logic [15:0] a;
      logic        wr;
      a = 16'($urandom_range(0, 16'hFFFF));
      if (a == 16'h4014) a = 16'h4015;
      wr = 1'($urandom_range(0, 1));
      cpu_addr  = a;
      cpu_wdata = 8'($urandom);
      cpu_write = wr;
      cpu_read  = !wr;
      tick      = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (bus_addr !== a || bus_wdata !== cpu_wdata || bus_read !== !wr || bus_write !== wr ||
          cpu_rdata !== mem[a] || dma_busy !== 1'b0) begin
        errors++;
        $display("FAIL passthrough_rand: addr=%h wd=%h rd=%b wr=%b rdata=%h busy=%b required %h %h %b %b %h 0",
                 bus_addr, bus_wdata, bus_read, bus_write, cpu_rdata, dma_busy,
                 a, cpu_wdata, !wr, wr, mem[a]);
      end
      @(negedge clk);
    end
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic test_tick_gating;
    int n;
    logic hp;
    cpu_addr  = 16'h4014;
    cpu_wdata = 8'h33;
    cpu_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0);
      checks++;
      if (dma_busy !== 1'b0) begin
        errors++;
        $display("FAIL gated_trigger: busy=%b required 0", dma_busy);
      end
    end
    cpu_write = 1'b0;
    cycle(1'b1);
    checks++;
    if (dma_busy !== 1'b0) begin
      errors++;
      $display("FAIL gated_trigger_late: busy=%b required 0", dma_busy);
    end
    hp = 1'($urandom_range(0, 1));
    start_dma(8'($urandom), hp);
    n = 0;
    while (dma_busy === 1'b1 && n < 6000) begin
      cycle(1'($urandom_range(0, 1)));
      n++;
    end
    end_checks("tick_gating", n, 6000, hp);
  endtask

  task automatic test_full_transfer;
    int n;
    start_dma(8'h02, 1'b1);
    n = 0;
    while (dma_busy === 1'b1 && n < 3000) begin
      cycle(1'b1);
      n++;
    end
    end_checks("full_transfer", n, 3000, 1'b1);
  endtask

  task automatic test_align;
    int n;
    start_dma(8'h02, 1'b0);
    n = 0;
    while (dma_busy === 1'b1 && n < 3000) begin
      cycle(1'b1);
      n++;
    end
    end_checks("align", n, 3000, 1'b0);
  endtask

  task automatic test_wrap;
    int n;
    logic hp;
    hp = 1'($urandom_range(0, 1));
    start_dma(8'hFF, hp);
    n = 0;
    while (dma_busy === 1'b1 && n < 3000) begin
      cycle(1'b1);
      n++;
    end
    end_checks("wrap", n, 3000, hp);
  endtask

  task automatic test_reset_mid;
    int n;
    start_dma(8'($urandom), 1'($urandom_range(0, 1)));
    n = 0;
    while (wr_seen < 64 && n < 500) begin
      cycle(1'b1);
      n++;
    end
    checks++;
    if (n >= 500 || dbg_cnt !== 8'h40) begin
      errors++;
      $display("FAIL reset_mid_reach: writes=%0d cnt=%h required 64 writes cnt=40", wr_seen, dbg_cnt);
    end
    tick = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (dma_busy !== 1'b0 || dbg_state !== 3'd0 || dbg_cnt !== 8'h00 || cpu_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_state: busy=%b state=%0d cnt=%0h cpu_en=%b required 0 0 00 1",
               dma_busy, dbg_state, dbg_cnt, cpu_en);
    end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (bus_write !== 1'b0 || dma_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet: bus_write=%b busy=%b addr=%h required 0 0", bus_write, dma_busy, bus_addr);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tick_cnt = 0;
    busy_ticks = 0;
    quiet_ticks = 0;
    wr_seen = 0;
    snap_valid = 0;
    reset = 1'b1;
    tick = 1'b0;
    cpu_addr = 16'h0000;
    cpu_wdata = 8'h00;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    @(negedge clk);
    test_reset();
    test_passthrough();
    test_tick_gating();
    test_full_transfer();
    test_align();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
